// File: rtl/imem_loader_if.sv
// Loader-side bundle: start request, byte stream from the producer, and the
// instruction-memory write port plus CPU status lines.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start_i;
  logic [ADDR_W:0]   nwords_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] wraddr_o;
  logic [31:0]       wrdata_o;
  logic              cpu_stall_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport slave (
    input  start_i, nwords_i, byte_valid_i, byte_data_i,
    output byte_ready_o, we_o, wraddr_o, wrdata_o,
    output cpu_stall_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, nwords_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, we_o, wraddr_o, wrdata_o,
    input  cpu_stall_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/imem_loader.sv
// Streams little-endian program bytes into 32-bit words and writes them into
// the instruction memory, stalling the CPU while the load is in progress.
module imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic         clk_w,
  input  logic         rst_ni,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  localparam logic [ADDR_W:0]   MaxWords = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0]   CntOne   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AddrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   nwords_q, nwords_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;

  logic start_ok;
  logic last_word;

  assign start_ok  = (bus.nwords_i != '0) && (bus.nwords_i <= MaxWords);
  // Words written so far is addr_q+1 during WRITE, so this never lets addr wrap.
  assign last_word = (({1'b0, addr_q} + CntOne) == nwords_q);

  always_ff @(posedge clk_w or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      nwords_q <= '0;
      word_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      nwords_q <= nwords_d;
      word_q   <= word_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    nwords_d = nwords_q;
    word_d   = word_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (start_ok) begin
            nwords_d = bus.nwords_i;
            addr_d   = '0;
            cnt_d    = '0;
            word_d   = '0;
            state_d  = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (bus.byte_valid_i) begin
          unique case (cnt_q)
            2'd0: word_d[7:0]   = bus.byte_data_i;
            2'd1: word_d[15:8]  = bus.byte_data_i;
            2'd2: word_d[23:16] = bus.byte_data_i;
            2'd3: word_d[31:24] = bus.byte_data_i;
            default: word_d = word_q;
          endcase
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = COLLECT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.byte_ready_o = (state_q == COLLECT);
    bus.we_o         = (state_q == WRITE);
    bus.wraddr_o     = addr_q;
    bus.wrdata_o     = word_q;
    bus.cpu_stall_o  = (state_q == COLLECT) || (state_q == WRITE);
    bus.busy_o       = (state_q != IDLE);
    bus.done_o       = (state_q == DONE);
    bus.err_o        = err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a byte-stream
// reference model (expected words assembled from the byte list).
module tb_imem_loader;
  localparam int ADDR_W    = 6;
  localparam int MAX_WORDS = 64;

  typedef logic [7:0] byte_q_t[$];

  logic clk_w  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [ADDR_W+31:0] wr_log[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk_w (clk_w),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_w = ~clk_w;

  always @(negedge clk_w) begin
    if (bus.we_o === 1'b1) wr_log.push_back({bus.wraddr_o, bus.wrdata_o});
  end

  function automatic logic [63:0] out_vec();
    return 64'({bus.byte_ready_o, bus.we_o, bus.wraddr_o, bus.wrdata_o,
                bus.cpu_stall_o, bus.busy_o, bus.done_o, bus.err_o});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input string name, input int n, input int gap_pct,
                          input byte_q_t fixed, input bit poke_start);
    byte_q_t     bytes;
    logic [31:0] exp_w[$];
    int          idx;
    int          cyc;
    int          done_cyc;
    bit          v;
    for (int i = 0; i < 4 * n; i++)
      bytes.push_back(i < fixed.size() ? fixed[i] : 8'($urandom));
    for (int w = 0; w < n; w++)
      exp_w.push_back({bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]});
    wr_log.delete();
    @(negedge clk_w);
    bus.start_i      = 1'b1;
    bus.nwords_i     = 7'(n);
    bus.byte_valid_i = 1'b0;
    @(negedge clk_w);
    bus.start_i = 1'b0;
    idx = 0;
    cyc = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 20 * n + 200) begin
      check({name, " busy"}, bus.busy_o, 1'b1);
      check({name, " err"}, bus.err_o, 1'b0);
      if (bus.we_o) check({name, " ready in write"}, bus.byte_ready_o, 1'b0);
      if (bus.done_o) begin
        check({name, " stall at done"}, bus.cpu_stall_o, 1'b0);
        done_cyc = cyc;
        bus.byte_valid_i = 1'b0;
      end else begin
        check({name, " stall"}, bus.cpu_stall_o, 1'b1);
        bus.start_i  = poke_start && (cyc == 7 || cyc == 150);
        bus.nwords_i = 7'd1;
        v = (idx < 4 * n) && ($urandom_range(0, 99) >= gap_pct);
        bus.byte_valid_i = v;
        bus.byte_data_i  = v ? bytes[idx] : 8'($urandom);
        if (v && bus.byte_ready_o) idx++;
        @(negedge clk_w);
        cyc++;
      end
    end
    bus.start_i = 1'b0;
    check({name, " done seen"}, done_cyc >= 0, 1'b1);
    if (gap_pct == 0) check({name, " latency"}, 64'(done_cyc), 64'(5 * n));
    check({name, " bytes consumed"}, 64'(idx), 64'(4 * n));
    @(negedge clk_w);
    check({name, " idle busy"}, bus.busy_o, 1'b0);
    check({name, " idle done"}, bus.done_o, 1'b0);
    check({name, " write count"}, 64'(wr_log.size()), 64'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++)
      check($sformatf("%s write %0d", name, i), 64'(wr_log[i]),
            64'({6'(i), exp_w[i]}));
    $display("load %s: n=%0d gap=%0d done_cycle=%0d writes=%0d", name, n, gap_pct,
             done_cyc, wr_log.size());
  endtask

  initial begin
    byte_q_t none;
    byte_q_t one_word;
    byte_q_t seq12;
    byte_q_t rb;
    int      bad_n[3];
    int      idx;
    int      cyc;
    int      n;
    int      gap;

    bus.start_i      = 1'b0;
    bus.nwords_i     = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = '0;
    one_word = '{8'h13, 8'h00, 8'h00, 8'h00};
    for (int i = 1; i <= 12; i++) seq12.push_back(8'(i));

    #12;
    check("reset outputs", out_vec(), 64'd0);
    @(negedge clk_w);
    rst_ni = 1'b1;
    @(negedge clk_w);
    check("idle outputs", out_vec(), 64'd0);

    run_load("single", 1, 0, one_word, 1'b0);
    run_load("three", 3, 0, seq12, 1'b0);
    run_load("gapped", 2, 40, none, 1'b0);

    bad_n = '{0, 65, 127};
    foreach (bad_n[k]) begin
      wr_log.delete();
      @(negedge clk_w);
      bus.start_i  = 1'b1;
      bus.nwords_i = 7'(bad_n[k]);
      @(negedge clk_w);
      bus.start_i = 1'b0;
      check($sformatf("err pulse n=%0d", bad_n[k]), bus.err_o, 1'b1);
      check($sformatf("err busy n=%0d", bad_n[k]), bus.busy_o, 1'b0);
      @(negedge clk_w);
      check($sformatf("err clear n=%0d", bad_n[k]), bus.err_o, 1'b0);
      check($sformatf("err idle n=%0d", bad_n[k]), bus.busy_o, 1'b0);
      check($sformatf("err no write n=%0d", bad_n[k]), 64'(wr_log.size()), 64'd0);
      $display("reject nwords=%0d", bad_n[k]);
    end

    run_load("full", 64, 0, none, 1'b1);
    repeat (4) begin
      n   = $urandom_range(1, 9);
      gap = $urandom_range(0, 60);
      run_load("random", n, gap, none, 1'b0);
    end

    // Abort a 4-word load partway into the second word.
    for (int i = 0; i < 16; i++) rb.push_back(8'($urandom));
    wr_log.delete();
    @(negedge clk_w);
    bus.start_i  = 1'b1;
    bus.nwords_i = 7'd4;
    @(negedge clk_w);
    bus.start_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 50) begin
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = rb[idx];
      if (bus.byte_ready_o) idx++;
      @(negedge clk_w);
      cyc++;
    end
    bus.byte_valid_i = 1'b0;
    check("abort bytes fed", 64'(idx), 64'd6);
    check("abort busy before reset", bus.busy_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1 check("abort async outputs", out_vec(), 64'd0);
    repeat (3) begin
      @(negedge clk_w);
      check("abort held outputs", out_vec(), 64'd0);
    end
    check("abort write count", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0)
      check("abort first word", 64'(wr_log[0]), 64'({6'd0, rb[3], rb[2], rb[1], rb[0]}));
    $display("abort after %0d bytes, writes=%0d", idx, wr_log.size());
    rst_ni = 1'b1;
    run_load("after reset", 2, 0, none, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
